// File: rtl/io_decode_pkg.sv
// Shared types and constants for the I/O address decoder and its config store.
package io_decode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_t;

  // Each decode window occupies a 16-byte slice of the config byte space.
  localparam int unsigned WIN_STRIDE = 16;

  // Byte offsets within a window slice.
  localparam int unsigned K_BASE = 0;
  localparam int unsigned K_MASK = 4;
  localparam int unsigned K_SLOT = 8;
  localparam int unsigned K_OP   = 9;
  localparam int unsigned K_WAIT = 10;
  localparam int unsigned K_TMO  = 11;

  // Bit positions in the op config byte.
  localparam int unsigned OP_RD = 0;
  localparam int unsigned OP_WR = 1;
  localparam int unsigned OP_EN = 7;

  // Bit positions in the packed 3-bit op field exported by the config store.
  localparam int unsigned OPF_RD = 0;
  localparam int unsigned OPF_WR = 1;
  localparam int unsigned OPF_EN = 2;
  localparam int unsigned OPF_W  = 3;

endpackage

// File: rtl/io_decode_cfg.sv
// Byte-addressed decode-window configuration store, exported as flat vectors.
module io_decode_cfg
  import io_decode_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_WIN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [7:0]                cfg_addr,
  input  logic [7:0]                cfg_wdata,
  output logic [NUM_WIN*ADDR_W-1:0] base_flat,
  output logic [NUM_WIN*ADDR_W-1:0] mask_flat,
  output logic [NUM_WIN*3-1:0]      slot_flat,
  output logic [NUM_WIN*OPF_W-1:0]  op_flat,
  output logic [NUM_WIN*8-1:0]      wait_flat,
  output logic [NUM_WIN*8-1:0]      tmo_flat
);

  logic [ADDR_W-1:0] base_r [NUM_WIN];
  logic [ADDR_W-1:0] mask_r [NUM_WIN];
  logic [2:0]        slot_r [NUM_WIN];
  logic [OPF_W-1:0]  op_r   [NUM_WIN];
  logic [7:0]        wait_r [NUM_WIN];
  logic [7:0]        tmo_r  [NUM_WIN];

  logic [3:0] win_sel;
  logic [3:0] k_sel;

  assign win_sel = 4'(cfg_addr / 8'(WIN_STRIDE));
  assign k_sel   = 4'(cfg_addr % 8'(WIN_STRIDE));

  // Byte writes into the selected window; base/mask bytes beyond ADDR_W have no storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < NUM_WIN; w++) begin
        base_r[w] <= '0;
        mask_r[w] <= '0;
        slot_r[w] <= '0;
        op_r[w]   <= '0;
        wait_r[w] <= '0;
        tmo_r[w]  <= '0;
      end
    end else if (cfg_we) begin
      for (int unsigned w = 0; w < NUM_WIN; w++) begin
        if (win_sel == 4'(w)) begin
          for (int unsigned b = 0; b < ADDR_W; b++) begin
            if (k_sel == 4'(K_BASE + b / 8)) base_r[w][b] <= cfg_wdata[b[2:0]];
            if (k_sel == 4'(K_MASK + b / 8)) mask_r[w][b] <= cfg_wdata[b[2:0]];
          end
          if (k_sel == 4'(K_SLOT)) slot_r[w] <= cfg_wdata[2:0];
          if (k_sel == 4'(K_OP))
            op_r[w] <= {cfg_wdata[OP_EN], cfg_wdata[OP_WR], cfg_wdata[OP_RD]};
          if (k_sel == 4'(K_WAIT)) wait_r[w] <= cfg_wdata;
          if (k_sel == 4'(K_TMO))  tmo_r[w]  <= cfg_wdata;
        end
      end
    end
  end

  // Flatten the per-window fields for the decoder.
  always_comb begin
    base_flat = '0;
    mask_flat = '0;
    slot_flat = '0;
    op_flat   = '0;
    wait_flat = '0;
    tmo_flat  = '0;
    for (int unsigned w = 0; w < NUM_WIN; w++) begin
      base_flat[w*ADDR_W +: ADDR_W] = base_r[w];
      mask_flat[w*ADDR_W +: ADDR_W] = mask_r[w];
      slot_flat[w*3 +: 3]           = slot_r[w];
      op_flat[w*OPF_W +: OPF_W]     = op_r[w];
      wait_flat[w*8 +: 8]           = wait_r[w];
      tmo_flat[w*8 +: 8]            = tmo_r[w];
    end
  end

endmodule

// File: rtl/io_decode_ctrl.sv
// Host I/O cycle decoder: window match, slot chip-select, wait/timeout handshake.
module io_decode_ctrl
  import io_decode_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_WIN   = 16,
  parameter int unsigned NUM_SLOTS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 iorq_n,
  input  logic                 r_w_,
  input  logic [NUM_SLOTS-1:0] dev_ready_n,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic [NUM_SLOTS-1:0] cs_n,
  output logic                 ready_n,
  output logic                 bus_err,
  output logic                 data_oe_n,
  output logic                 data_dir,
  output logic                 ff_oe_n,
  output logic                 win_valid,
  output logic [3:0]           win_index,
  output logic [7:0]           err_count
);

  logic [NUM_WIN*ADDR_W-1:0] base_flat;
  logic [NUM_WIN*ADDR_W-1:0] mask_flat;
  logic [NUM_WIN*3-1:0]      slot_flat;
  logic [NUM_WIN*OPF_W-1:0]  op_flat;
  logic [NUM_WIN*8-1:0]      wait_flat;
  logic [NUM_WIN*8-1:0]      tmo_flat;

  io_decode_cfg #(
    .ADDR_W  (ADDR_W),
    .NUM_WIN (NUM_WIN)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .base_flat (base_flat),
    .mask_flat (mask_flat),
    .slot_flat (slot_flat),
    .op_flat   (op_flat),
    .wait_flat (wait_flat),
    .tmo_flat  (tmo_flat)
  );

  state_t state, state_nxt;

  logic       hit;
  logic [3:0] hit_idx;
  logic [2:0] hit_slot;
  logic [7:0] hit_wait;
  logic [7:0] hit_tmo;

  logic       rw_q;
  logic [2:0] slot_q;
  logic [7:0] wait_cnt;
  logic [7:0] tmo_q;
  logic [7:0] acc_cnt;
  logic [7:0] acc_inc;
  logic       tmo_hit;
  logic       slot_rdy;
  logic [NUM_SLOTS-1:0] sel_n;

  // Priority window match: the first enabled window that matches wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_slot = '0;
    hit_wait = '0;
    hit_tmo  = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (!hit && op_flat[i*OPF_W + OPF_EN]
          && (((addr ^ base_flat[i*ADDR_W +: ADDR_W]) & mask_flat[i*ADDR_W +: ADDR_W]) == '0)
          && (r_w_ ? op_flat[i*OPF_W + OPF_RD] : op_flat[i*OPF_W + OPF_WR])) begin
        hit      = 1'b1;
        hit_idx  = 4'(i);
        hit_slot = slot_flat[i*3 +: 3];
        hit_wait = wait_flat[i*8 +: 8];
        hit_tmo  = tmo_flat[i*8 +: 8];
      end
    end
  end

  // Latched slot's chip-select pattern and ready; a slot beyond NUM_SLOTS never selects nor readies.
  always_comb begin
    sel_n    = '1;
    slot_rdy = 1'b0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (slot_q == 3'(s)) begin
        sel_n[s] = 1'b0;
        slot_rdy = dev_ready_n[s];
      end
    end
  end

  assign acc_inc  = acc_cnt + 8'd1;
  assign tmo_hit  = (tmo_q != 8'd0) && (acc_inc == tmo_q);
  assign data_dir = rw_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore outputs; abort beats timeout, timeout beats ready.
  always_comb begin
    state_nxt = state;
    cs_n      = '1;
    ready_n   = 1'b1;
    bus_err   = 1'b0;
    data_oe_n = 1'b1;
    ff_oe_n   = 1'b1;
    case (state)
      IDLE: begin
        if (!iorq_n) state_nxt = hit ? ACCESS : DONE;
      end
      ACCESS: begin
        cs_n      = sel_n;
        data_oe_n = !win_valid;
        if (iorq_n)                              state_nxt = IDLE;
        else if (tmo_hit)                        state_nxt = ERR;
        else if (wait_cnt == 8'd0 && slot_rdy)   state_nxt = DONE;
      end
      DONE: begin
        ready_n = 1'b0;
        if (win_valid) begin
          cs_n      = sel_n;
          data_oe_n = 1'b0;
        end else begin
          ff_oe_n = !rw_q;
        end
        if (iorq_n) state_nxt = IDLE;
      end
      ERR: begin
        ready_n = 1'b0;
        bus_err = 1'b1;
        if (iorq_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle attributes latched at decode, wait/timeout counting, error tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_index <= '0;
      rw_q      <= 1'b0;
      slot_q    <= '0;
      wait_cnt  <= '0;
      tmo_q     <= '0;
      acc_cnt   <= '0;
      err_count <= '0;
    end else begin
      if (state == IDLE && !iorq_n) begin
        win_valid <= hit;
        win_index <= hit_idx;
        rw_q      <= r_w_;
        slot_q    <= hit_slot;
        wait_cnt  <= hit_wait;
        tmo_q     <= hit_tmo;
        acc_cnt   <= '0;
      end
      if (state == ACCESS) begin
        if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
        acc_cnt <= acc_inc;
        if (iorq_n) begin
          win_valid <= 1'b0;
          win_index <= '0;
          rw_q      <= 1'b0;
        end else if (tmo_hit && err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_decode_ctrl.sv
// Randomised and directed bench for io_decode_ctrl against a transaction-level model.
module tb_io_decode_ctrl;

  localparam int unsigned NS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic          iorq_n;
  logic          r_w_;
  logic [NS-1:0] dev_ready_n;
  logic          cfg_we;
  logic [7:0]    cfg_addr;
  logic [7:0]    cfg_wdata;
  logic [NS-1:0] cs_n;
  logic          ready_n;
  logic          bus_err;
  logic          data_oe_n;
  logic          data_dir;
  logic          ff_oe_n;
  logic          win_valid;
  logic [3:0]    win_index;
  logic [7:0]    err_count;

  io_decode_ctrl #(
    .ADDR_W    (32),
    .NUM_WIN   (16),
    .NUM_SLOTS (NS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .iorq_n      (iorq_n),
    .r_w_        (r_w_),
    .dev_ready_n (dev_ready_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cs_n        (cs_n),
    .ready_n     (ready_n),
    .bus_err     (bus_err),
    .data_oe_n   (data_oe_n),
    .data_dir    (data_dir),
    .ff_oe_n     (ff_oe_n),
    .win_valid   (win_valid),
    .win_index   (win_index),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference configuration and error tally.
  logic [31:0] m_base [16];
  logic [31:0] m_mask [16];
  logic [2:0]  m_slot [16];
  logic [7:0]  m_op   [16];
  logic [7:0]  m_wait [16];
  logic [7:0]  m_tmo  [16];
  int unsigned m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("oe_excl", 64'(data_oe_n | ff_oe_n), 64'd1);
  endtask

  task automatic model_clear();
    for (int w = 0; w < 16; w++) begin
      m_base[w] = '0; m_mask[w] = '0; m_slot[w] = '0;
      m_op[w] = '0; m_wait[w] = '0; m_tmo[w] = '0;
    end
    m_err = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    int unsigned w, k;
    w = a / 16;
    k = a % 16;
    if (k <= 3)       m_base[w][k*8 +: 8]     = d;
    else if (k <= 7)  m_mask[w][(k-4)*8 +: 8] = d;
    else if (k == 8)  m_slot[w] = d[2:0];
    else if (k == 9)  m_op[w]   = d;
    else if (k == 10) m_wait[w] = d;
    else if (k == 11) m_tmo[w]  = d;
  endtask

  task automatic model_decode(input logic [31:0] a, input logic rw,
                              output logic hit, output int unsigned idx);
    hit = 1'b0;
    idx = 0;
    for (int w = 15; w >= 0; w--) begin
      if (m_op[w][7] && ((a ^ m_base[w]) & m_mask[w]) == 32'd0 && (rw ? m_op[w][0] : m_op[w][1])) begin
        hit = 1'b1;
        idx = w;
      end
    end
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic set_win(input int unsigned w, input logic [31:0] b, input logic [31:0] m,
                         input logic [7:0] s, input logic [7:0] op,
                         input logic [7:0] wt, input logic [7:0] to);
    logic [7:0] base_a;
    base_a = 8'(w * 16);
    for (int unsigned k = 0; k < 4; k++) begin
      cfg_wr(base_a + 8'(k), b[k*8 +: 8]);
      cfg_wr(base_a + 8'(4 + k), m[k*8 +: 8]);
    end
    cfg_wr(base_a + 8'd8, s);
    cfg_wr(base_a + 8'd9, op);
    cfg_wr(base_a + 8'd10, wt);
    cfg_wr(base_a + 8'd11, to);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cs"},   64'(cs_n), 64'h1F);
    chk({tag, "_rdy"},  64'(ready_n), 64'd1);
    chk({tag, "_berr"}, 64'(bus_err), 64'd0);
    chk({tag, "_doe"},  64'(data_oe_n), 64'd1);
    chk({tag, "_ffoe"}, 64'(ff_oe_n), 64'd1);
    chk({tag, "_dir"},  64'(data_dir), 64'd0);
    chk({tag, "_wv"},   64'(win_valid), 64'd0);
    chk({tag, "_wi"},   64'(win_index), 64'd0);
    chk({tag, "_ecnt"}, 64'(err_count), 64'd0);
  endtask

  // One host cycle. rdy_at: first ACCESS edge (1-based) at which the slot reports ready.
  // Optionally a config byte is written on the very decode edge.
  task automatic run_txn(input logic [31:0] a, input logic rw, input int unsigned rdy_at,
                         input logic cw_en, input logic [7:0] cw_a, input logic [7:0] cw_d);
    logic hit, is_err;
    int unsigned idx, s, fin;
    logic [NS-1:0] cs_exp;
    model_decode(a, rw, hit, idx);
    s = hit ? m_slot[idx] : 0;
    cs_exp = '1;
    if (hit && s < NS) cs_exp[s] = 1'b0;
    fin = 0;
    is_err = 1'b0;
    if (hit) begin
      fin = (m_wait[idx] + 1 > rdy_at) ? m_wait[idx] + 1 : rdy_at;
      if (m_tmo[idx] != 0 && m_tmo[idx] <= fin) begin
        fin = m_tmo[idx];
        is_err = 1'b1;
      end
    end
    addr = a; r_w_ = rw; iorq_n = 1'b0;
    dev_ready_n = NS'($urandom);
    if (cw_en) begin cfg_we = 1'b1; cfg_addr = cw_a; cfg_wdata = cw_d; end
    tick();
    cfg_we = 1'b0;
    if (cw_en) model_write(cw_a, cw_d);
    chk("dec_wv", 64'(win_valid), 64'(hit));
    chk("dec_dir", 64'(data_dir), 64'(rw));
    if (!hit) begin
      chk("miss_rdy", 64'(ready_n), 64'd0);
      chk("miss_cs", 64'(cs_n), 64'h1F);
      chk("miss_ffoe", 64'(ff_oe_n), 64'(!rw));
      chk("miss_doe", 64'(data_oe_n), 64'd1);
      chk("miss_berr", 64'(bus_err), 64'd0);
    end else begin
      chk("acc_wi", 64'(win_index), 64'(idx));
      chk("acc_cs", 64'(cs_n), 64'(cs_exp));
      chk("acc_rdy", 64'(ready_n), 64'd1);
      chk("acc_doe", 64'(data_oe_n), 64'd0);
      for (int unsigned c = 1; c <= fin; c++) begin
        dev_ready_n = NS'($urandom);
        dev_ready_n[s] = (c >= rdy_at);
        tick();
        if (c < fin) begin
          chk("wait_rdy", 64'(ready_n), 64'd1);
          chk("wait_cs", 64'(cs_n), 64'(cs_exp));
        end else begin
          chk("end_rdy", 64'(ready_n), 64'd0);
          chk("end_berr", 64'(bus_err), 64'(is_err));
          chk("end_cs", 64'(cs_n), is_err ? 64'h1F : 64'(cs_exp));
          chk("end_doe", 64'(data_oe_n), 64'(is_err));
          chk("end_ffoe", 64'(ff_oe_n), 64'd1);
        end
      end
      if (is_err && m_err < 255) m_err++;
    end
    chk("ecnt", 64'(err_count), 64'(m_err));
    iorq_n = 1'b1;
    tick();
    chk("rel_rdy", 64'(ready_n), 64'd1);
    chk("rel_cs", 64'(cs_n), 64'h1F);
    chk("rel_berr", 64'(bus_err), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int unsigned rw_win;
    rst = 1'b1; addr = '0; iorq_n = 1'b1; r_w_ = 1'b0; dev_ready_n = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_clear();
    tick();
    chk_reset_outs("rst");
    tick();
    rst = 1'b0;
    tick();

    // Basic read, zero wait.
    set_win(0, 32'h40, 32'hF0, 8'd2, 8'h83, 8'd0, 8'd0);
    run_txn(32'h45, 1'b1, 1, 1'b0, 8'h0, 8'h0);
    // Three wait states, device late.
    cfg_wr(8'd10, 8'd3);
    run_txn(32'h45, 1'b1, 3, 1'b0, 8'h0, 8'h0);
    // Unmapped read and write.
    run_txn(32'h80, 1'b1, 1, 1'b0, 8'h0, 8'h0);
    run_txn(32'h80, 1'b0, 1, 1'b0, 8'h0, 8'h0);
    // Timeout of 5 with device never ready.
    cfg_wr(8'd10, 8'd0);
    cfg_wr(8'd11, 8'd5);
    run_txn(32'h45, 1'b1, 1000, 1'b0, 8'h0, 8'h0);
    run_txn(32'h4A, 1'b0, 1000, 1'b0, 8'h0, 8'h0);
    // Overlapping windows 1 and 3: lowest index wins.
    set_win(1, 32'h100, 32'hF00, 8'd3, 8'h83, 8'd2, 8'd0);
    set_win(3, 32'h100, 32'hF00, 8'd4, 8'h83, 8'd0, 8'd0);
    run_txn(32'h123, 1'b1, 1, 1'b0, 8'h0, 8'h0);

    // Abort during ACCESS.
    addr = 32'h123; r_w_ = 1'b1; iorq_n = 1'b0; dev_ready_n = '0;
    tick();
    chk("abt_cs", 64'(cs_n), 64'h17);
    tick();
    iorq_n = 1'b1;
    tick();
    chk("abt_cs2", 64'(cs_n), 64'h1F);
    chk("abt_rdy", 64'(ready_n), 64'd1);
    chk("abt_wv", 64'(win_valid), 64'd0);
    chk("abt_doe", 64'(data_oe_n), 64'd1);
    chk("abt_ecnt", 64'(err_count), 64'(m_err));

    // Config write on the decode edge only affects later cycles.
    run_txn(32'h123, 1'b1, 1, 1'b1, 8'h19, 8'h00);
    run_txn(32'h123, 1'b1, 1, 1'b0, 8'h0, 8'h0);

    // Randomised windows and cycles.
    for (int unsigned w = 4; w < 10; w++)
      set_win(w, $urandom, $urandom, 8'($urandom_range(0, NS - 1)),
              {($urandom_range(0, 3) != 0), 5'b0, 2'($urandom)},
              8'($urandom_range(0, 3)), 8'($urandom_range(0, 7)));
    for (int unsigned t = 0; t < 150; t++) begin
      rw_win = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ra = $urandom;
      else ra = m_base[rw_win] ^ ($urandom & ~m_mask[rw_win]);
      run_txn(ra, 1'($urandom), $urandom_range(1, 8), 1'b0, 8'h0, 8'h0);
    end

    // Reset in the middle of ACCESS.
    cfg_wr(8'd10, 8'd3);
    cfg_wr(8'd11, 8'd0);
    addr = 32'h45; r_w_ = 1'b1; iorq_n = 1'b0; dev_ready_n = '0;
    tick();
    chk("mid_cs", 64'(cs_n), 64'h1B);
    rst = 1'b1;
    tick();
    chk_reset_outs("midrst");
    rst = 1'b0;
    iorq_n = 1'b1;
    model_clear();
    tick();
    run_txn(32'h45, 1'b1, 1, 1'b0, 8'h0, 8'h0);

    // Error counter saturation.
    set_win(0, 32'h40, 32'hF0, 8'd2, 8'h83, 8'd0, 8'd1);
    for (int unsigned t = 0; t < 260; t++)
      run_txn(32'h45, 1'b1, 1000, 1'b0, 8'h0, 8'h0);
    chk("ecnt_sat", 64'(err_count), 64'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
